// File: rtl/buffer_read_streamer.sv
// Read-side sequencer for local_buffer: turns (base, len) commands into one buffer read per cycle
// and streams the returned words out through a credit-tracked FIFO as a valid/ready/last stream.
module buffer_read_streamer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              buf_ce,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic                rd_pending_q, rd_pending_d;
  logic                last_pending_q, last_pending_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic                fifo_last_q [FIFO_DEPTH];

  logic                fifo_empty, push, pop, head_last, credit, issue;
  logic [OCC_W-1:0]    occ;

  assign fifo_empty = (count_q == '0);
  assign push       = rd_pending_q;
  assign pop        = !fifo_empty && out_ready;
  assign head_last  = fifo_last_q[rd_ptr_q];

  // Reads already in flight count against the FIFO, so an issued read always has a slot waiting.
  assign occ    = OCC_W'(count_q) + OCC_W'(rd_pending_q) - OCC_W'(pop);
  assign credit = (occ < OCC_W'(FIFO_DEPTH));
  assign issue  = (state_q == ISSUE) && credit;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d        = state_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    done_d         = 1'b0;
    rd_pending_d   = issue;
    last_pending_d = issue && (rem_q == (ADDR_W+1)'(1));
    wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d       = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d        = count_q + CNT_W'(push) - CNT_W'(pop);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_base;
            rem_d   = cmd_len;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      rem_q          <= '0;
      rd_pending_q   <= 1'b0;
      last_pending_q <= 1'b0;
      done_q         <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      rd_pending_q   <= rd_pending_d;
      last_pending_q <= last_pending_d;
      done_q         <= done_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates out_valid, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= buf_rdata;
      fifo_last_q[wr_ptr_q] <= last_pending_q;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign buf_ce    = issue;
  assign buf_we    = 1'b0;
  assign buf_addr  = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = !fifo_empty && head_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
